// File: rtl/mul_unit.sv
// Iterative RV32M multiplier (mul/mulh/mulhsu/mulhu): radix-2 shift-add on operand magnitudes, then sign fix.
// Operands are captured on an accepted start; the edge 33 edges later moves the unit to DONE (34 edges counting the capture edge).
module mul_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mulstart,
    input  logic [1:0]      mulctl,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic [XLEN-1:0] mulres,
    output logic            muldone,
    output logic            mulbusy
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          ctl_q, ctl_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    // Upper half accumulates partial sums; lower half holds the multiplier as it shifts out.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     mulres_q, mulres_d;

    logic                sign1, sign2;
    logic [XLEN-1:0]     mag1, mag2;
    logic [XLEN:0]       sum;
    logic [2*XLEN-1:0]   prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctl_d    = ctl_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mulres_d = mulres_q;

        sign1 = rs1[XLEN-1] & ((mulctl == 2'b01) | (mulctl == 2'b10));
        sign2 = rs2[XLEN-1] & (mulctl == 2'b01);
        mag1  = sign1 ? (~rs1 + 1'b1) : rs1;
        mag2  = sign2 ? (~rs2 + 1'b1) : rs2;

        sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        prod = neg_q ? (~acc_q + 1'b1) : acc_q;

        unique case (state_q)
            IDLE: begin
                if (mulstart && !kill) begin
                    ctl_d   = mulctl;
                    neg_d   = sign1 ^ sign2;
                    mcand_d = mag1;
                    acc_d   = {{XLEN{1'b0}}, mag2};
                    cnt_d   = CW'(XLEN - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = {sum, acc_q[XLEN-1:1]};
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            FIX: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = prod;
                    mulres_d = (ctl_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ctl_q    <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mulres_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctl_q    <= ctl_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mulres_q <= mulres_d;
        end
    end

    assign mulres  = mulres_q;
    assign muldone = (state_q == DONE);
    assign mulbusy = (state_q != IDLE);

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vector table, random ops against a 64-bit arithmetic model, and corner sequences.
module tb_mul_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mulstart = 1'b0;
    logic [1:0]  mulctl = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        kill = 1'b0;
    logic [31:0] mulres;
    logic        muldone;
    logic        mulbusy;

    int checks = 0;
    int failures = 0;

    mul_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .mulstart(mulstart), .mulctl(mulctl),
        .rs1(rs1), .rs2(rs2), .kill(kill),
        .mulres(mulres), .muldone(muldone), .mulbusy(mulbusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Extend each operand to 64 bits according to RV32M signedness and multiply.
    function automatic logic [31:0] ref_mul(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (c == 2'b01 || c == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (c == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (c == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
    task automatic do_op(input string name, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        mulctl = c; rs1 = a; rs2 = b; mulstart = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        mulstart = 1'b0;
        rs1 = $urandom; rs2 = $urandom; mulctl = 2'($urandom);
        while (!muldone && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = mulres;
        if (!muldone) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no muldone within %0d edges", name, lat);
        end
        @(posedge clk);
        @(negedge clk);
        check({name, "_pulse"}, {30'b0, muldone, mulbusy}, 32'd0);
    endtask

    initial begin
        vec_t        vt[$];
        logic [31:0] res, prev;
        int          lat, dones;
        logic        early_idle;
        logic [1:0]  c;
        logic [31:0] a, b;

        vt.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
        vt.push_back('{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
        vt.push_back('{2'b01, 32'h80000000, 32'h80000000, 32'h40000000});
        vt.push_back('{2'b01, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF});
        vt.push_back('{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1});
        vt.push_back('{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
        vt.push_back('{2'b10, 32'h7FFFFFFF, 32'h00000002, 32'h00000000});
        vt.push_back('{2'b11, 32'h80000000, 32'h00000002, 32'h00000001});
        vt.push_back('{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF});

        repeat (2) @(negedge clk);
        check("reset_outputs", {mulres[29:0], muldone, mulbusy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[i]) begin
            do_op($sformatf("vec%0d", i), vt[i].ctl, vt[i].a, vt[i].b, res, lat);
            check($sformatf("vec%0d_res", i), res, vt[i].exp);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd34);
        end

        for (int i = 0; i < 16; i++) begin
            c = 2'($urandom);
            a = $urandom;
            b = (i % 4 == 0) ? 32'h80000000 : $urandom;
            do_op("rand", c, a, b, res, lat);
            check($sformatf("rand%0d_res", i), res, ref_mul(c, a, b));
            check($sformatf("rand%0d_lat", i), 32'(lat), 32'd34);
        end

        // Asynchronous reset in the middle of BUSY; mulres is nonzero beforehand.
        mulctl = 2'b00; rs1 = 32'd1234; rs2 = 32'd99; mulstart = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mulstart = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", {mulres[29:0], muldone, mulbusy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle", {31'b0, mulbusy}, 32'd0);
        do_op("after_rst", 2'b00, 32'd7, 32'd6, res, lat);
        check("after_rst_res", res, 32'd42);
        check("after_rst_lat", 32'(lat), 32'd34);

        // Start held high through BUSY and DONE with changing operands: only the first is taken.
        mulctl = 2'b11; rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0; mulstart = 1'b1;
        @(posedge clk);
        dones = 0; early_idle = 1'b0; res = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (muldone) begin
                dones++;
                res = mulres;
            end
            if (!mulbusy) begin
                if (dones == 0) early_idle = 1'b1;
                break;
            end
            rs1 = $urandom; rs2 = $urandom; mulctl = 2'($urandom);
            @(posedge clk);
        end
        mulstart = 1'b0;
        check("hold_start_dones", 32'(dones), 32'd1);
        check("hold_start_res", res, ref_mul(2'b11, 32'h12345678, 32'h9ABCDEF0));
        check("hold_start_busy", {31'b0, early_idle}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("hold_start_idle", {31'b0, mulbusy}, 32'd0);

        // Kill in BUSY: back to IDLE, no done pulse, result unchanged.
        prev = mulres;
        mulctl = 2'b00; rs1 = 32'd1000; rs2 = 32'd1000; mulstart = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mulstart = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        check("kill_idle", {31'b0, mulbusy}, 32'd0);
        check("kill_mulres", mulres, prev);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (muldone) dones++;
        end
        check("kill_no_done", 32'(dones), 32'd0);

        // Kill together with start in IDLE drops the start.
        mulctl = 2'b00; rs1 = 32'd3; rs2 = 32'd3; mulstart = 1'b1; kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mulstart = 1'b0; kill = 1'b0;
        check("kill_start_busy", {31'b0, mulbusy}, 32'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (muldone) dones++;
        end
        check("kill_start_no_done", 32'(dones), 32'd0);
        check("kill_start_mulres", mulres, prev);

        // Back-to-back: second start in the IDLE cycle right after DONE.
        do_op("b2b_a", 2'b00, 32'd11, 32'd13, res, lat);
        check("b2b_a_res", res, 32'd143);
        do_op("b2b_b", 2'b01, 32'hFFFFFFF6, 32'h7FFFFFFF, res, lat);
        check("b2b_b_res", res, ref_mul(2'b01, 32'hFFFFFFF6, 32'h7FFFFFFF));
        check("b2b_b_lat", 32'(lat), 32'd34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
